// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-master round-robin arbiter in front of an Avalon-MM SDRAM controller
// Registers each granted command towards the controller and steers in-order read returns back by ID.
module sdram_port_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int MAX_PENDING = 4,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdatavalid,
  output logic              err_proto,
  output logic              err_orphan
);

  localparam int PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CW = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0] MAXP_C = CW'(MAX_PENDING);
  localparam logic [PW-1:0] LASTP_C = PW'(MAX_PENDING - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] s_address_q, s_address_d;
  logic              s_read_q, s_read_d;
  logic              s_write_q, s_write_d;
  logic [DATA_W-1:0] s_writedata_q, s_writedata_d;
  logic [BE_W-1:0]   s_byteenable_q, s_byteenable_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [MAX_PENDING-1:0] ids_q, ids_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic              m0_rdv_q, m0_rdv_d, m1_rdv_q, m1_rdv_d;
  logic              err_proto_q, err_proto_d, err_orphan_q, err_orphan_d;

  logic room, elig0, elig1, slot_open, capture, win;
  logic win_write, win_read, push, pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LASTP_C) ? '0 : p + PW'(1);
  endfunction

  // Eligibility uses the registered count, so a same-cycle return never unblocks a read.
  assign room      = (cnt_q < MAXP_C);
  assign elig0     = m0_write | (m0_read & room);
  assign elig1     = m1_write | (m1_read & room);
  assign slot_open = (state_q == IDLE) | ~s_waitrequest;
  assign capture   = reset_reset_n & slot_open & (elig0 | elig1);
  assign win       = (elig0 & elig1) ? ~last_q : elig1;
  assign win_write = win ? m1_write : m0_write;
  assign win_read  = win ? m1_read : m0_read;
  assign push      = capture & ~win_write & win_read;
  assign pop       = s_readdatavalid & (cnt_q != '0);

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    s_address_d    = s_address_q;
    s_read_d       = s_read_q;
    s_write_d      = s_write_q;
    s_writedata_d  = s_writedata_q;
    s_byteenable_d = s_byteenable_q;
    cnt_d          = cnt_q;
    wptr_d         = wptr_q;
    rptr_d         = rptr_q;
    ids_d          = ids_q;
    m0_rdata_d     = m0_rdata_q;
    m1_rdata_d     = m1_rdata_q;
    m0_rdv_d       = 1'b0;
    m1_rdv_d       = 1'b0;
    err_proto_d    = err_proto_q | (m0_read & m0_write) | (m1_read & m1_write);
    err_orphan_d   = err_orphan_q | (s_readdatavalid & (cnt_q == '0));

    if (capture) begin
      state_d        = ISSUE;
      last_d         = win;
      s_address_d    = win ? m1_address : m0_address;
      s_writedata_d  = win ? m1_writedata : m0_writedata;
      s_byteenable_d = win ? m1_byteenable : m0_byteenable;
      s_write_d      = win_write;
      s_read_d       = win_read & ~win_write;
    end else if ((state_q == ISSUE) && !s_waitrequest) begin
      state_d   = IDLE;
      s_read_d  = 1'b0;
      s_write_d = 1'b0;
    end

    if (push) begin
      ids_d[wptr_q] = win;
      wptr_d        = ptr_next(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_next(rptr_q);
      if (ids_q[rptr_q]) begin
        m1_rdata_d = s_readdata;
        m1_rdv_d   = 1'b1;
      end else begin
        m0_rdata_d = s_readdata;
        m0_rdv_d   = 1'b1;
      end
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q        <= IDLE;
      last_q         <= 1'b1;
      s_address_q    <= '0;
      s_read_q       <= 1'b0;
      s_write_q      <= 1'b0;
      s_writedata_q  <= '0;
      s_byteenable_q <= '0;
      cnt_q          <= '0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      ids_q          <= '0;
      m0_rdata_q     <= '0;
      m1_rdata_q     <= '0;
      m0_rdv_q       <= 1'b0;
      m1_rdv_q       <= 1'b0;
      err_proto_q    <= 1'b0;
      err_orphan_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      s_address_q    <= s_address_d;
      s_read_q       <= s_read_d;
      s_write_q      <= s_write_d;
      s_writedata_q  <= s_writedata_d;
      s_byteenable_q <= s_byteenable_d;
      cnt_q          <= cnt_d;
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      ids_q          <= ids_d;
      m0_rdata_q     <= m0_rdata_d;
      m1_rdata_q     <= m1_rdata_d;
      m0_rdv_q       <= m0_rdv_d;
      m1_rdv_q       <= m1_rdv_d;
      err_proto_q    <= err_proto_d;
      err_orphan_q   <= err_orphan_d;
    end
  end

  assign m0_waitrequest   = ~(capture & ~win);
  assign m1_waitrequest   = ~(capture & win);
  assign m0_readdata      = m0_rdata_q;
  assign m1_readdata      = m1_rdata_q;
  assign m0_readdatavalid = m0_rdv_q;
  assign m1_readdatavalid = m1_rdv_q;
  assign s_address        = s_address_q;
  assign s_read           = s_read_q;
  assign s_write          = s_write_q;
  assign s_writedata      = s_writedata_q;
  assign s_byteenable     = s_byteenable_q;
  assign err_proto        = err_proto_q;
  assign err_orphan       = err_orphan_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - randomized bench for sdram_port_arbiter against a transaction-level model
// The model tracks the presented command, the grant history and a queue of outstanding read owners.
module tb_sdram_port_arbiter;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int BE_W   = 2;
  localparam int MAXP   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
  logic              m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [DATA_W-1:0] m0_writedata = '0, m1_writedata = '0;
  logic [BE_W-1:0]   m0_byteenable = '0, m1_byteenable = '0;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] s_address;
  logic              s_read, s_write;
  logic [DATA_W-1:0] s_writedata;
  logic [BE_W-1:0]   s_byteenable;
  logic              s_waitrequest = 1'b0;
  logic [DATA_W-1:0] s_readdata = '0;
  logic              s_readdatavalid = 1'b0;
  logic              err_proto, err_orphan;

  int vectors = 0;
  int errors  = 0;

  // Model state: the command currently presented, the last grantee and outstanding read owners.
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;
  logic [BE_W-1:0]   e_be;
  logic              e_rd, e_wr, e_last, e_ep, e_eo;
  logic [DATA_W-1:0] e_rdata [2];
  logic              e_rdv [2];
  bit                mq[$];

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAXP)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .err_proto(err_proto), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    e_addr = '0; e_wdata = '0; e_be = '0; e_rd = 0; e_wr = 0; e_last = 1; e_ep = 0; e_eo = 0;
    e_rdata[0] = '0; e_rdata[1] = '0; e_rdv[0] = 0; e_rdv[1] = 0;
    mq.delete();
  endtask

  task automatic clear_inputs();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    s_waitrequest = 0; s_readdatavalid = 0;
  endtask

  // Called at a falling edge with the cycle's inputs applied; compares, advances the model, returns at the next falling edge.
  task automatic tick();
    bit el0, el1, cap, w, id;
    #1;
    cap = 0; w = 0;
    if (rst_n) begin
      el0 = m0_write || (m0_read && (mq.size() < MAXP));
      el1 = m1_write || (m1_read && (mq.size() < MAXP));
      cap = ((!e_rd && !e_wr) || !s_waitrequest) && (el0 || el1);
      w   = (el0 && el1) ? !e_last : el1;
    end
    chk("m0_waitrequest", m0_waitrequest, !(cap && !w));
    chk("m1_waitrequest", m1_waitrequest, !(cap && w));
    chk("s_read", s_read, e_rd);
    chk("s_write", s_write, e_wr);
    chk("s_address", s_address, e_addr);
    chk("s_writedata", s_writedata, e_wdata);
    chk("s_byteenable", s_byteenable, e_be);
    chk("m0_readdata", m0_readdata, e_rdata[0]);
    chk("m1_readdata", m1_readdata, e_rdata[1]);
    chk("m0_readdatavalid", m0_readdatavalid, e_rdv[0]);
    chk("m1_readdatavalid", m1_readdatavalid, e_rdv[1]);
    chk("err_proto", err_proto, e_ep);
    chk("err_orphan", err_orphan, e_eo);
    if (rst_n) begin
      if ((m0_read && m0_write) || (m1_read && m1_write)) e_ep = 1;
      e_rdv[0] = 0; e_rdv[1] = 0;
      if (s_readdatavalid) begin
        if (mq.size() != 0) begin
          id = mq.pop_front();
          e_rdata[id] = s_readdata;
          e_rdv[id] = 1;
        end else begin
          e_eo = 1;
        end
      end
      if (cap) begin
        e_addr  = w ? m1_address : m0_address;
        e_wdata = w ? m1_writedata : m0_writedata;
        e_be    = w ? m1_byteenable : m0_byteenable;
        e_wr    = w ? m1_write : m0_write;
        e_rd    = !e_wr;
        if (!e_wr) mq.push_back(w);
        e_last  = w;
      end else if (!s_waitrequest) begin
        e_rd = 0; e_wr = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 0;
    model_reset();
    for (int i = 0; i < n; i++) tick();
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    clear_inputs();
    @(negedge clk);
    do_reset(2);

    // Single m0 write.
    m0_write = 1; m0_address = 24'h000010; m0_writedata = 16'hBEEF; m0_byteenable = 2'b11;
    #1;
    chk("t1_m0_wq_low", m0_waitrequest, 0);
    chk("t1_m1_wq_high", m1_waitrequest, 1);
    tick();
    clear_inputs();
    #1;
    chk("t1_s_write", s_write, 1);
    chk("t1_s_address", s_address, 32'h10);
    chk("t1_s_writedata", s_writedata, 32'hBEEF);
    tick();
    #1;
    chk("t1_s_write_drop", s_write, 0);
    tick();

    // Two reads, in-order returns to their owners.
    m0_read = 1; m0_address = 24'h000100;
    tick();
    m0_read = 0; m1_read = 1; m1_address = 24'h000200;
    tick();
    m1_read = 0; s_readdatavalid = 1; s_readdata = 16'h1111;
    tick();
    s_readdata = 16'h2222;
    #1;
    chk("t3_m0_rdv", m0_readdatavalid, 1);
    chk("t3_m0_rdata", m0_readdata, 32'h1111);
    tick();
    s_readdatavalid = 0;
    #1;
    chk("t3_m1_rdv", m1_readdatavalid, 1);
    chk("t3_m1_rdata", m1_readdata, 32'h2222);
    chk("t3_m0_rdv_idle", m0_readdatavalid, 0);
    chk("t3_m0_rdata_hold", m0_readdata, 32'h1111);
    tick();

    // Controller stall during an m1 write.
    m1_write = 1; m1_address = 24'h000333; m1_writedata = 16'hA5A5;
    tick();
    m1_write = 0; m0_write = 1; m0_address = 24'h000044; s_waitrequest = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_stall_s_write", s_write, 1);
      chk("t4_stall_s_address", s_address, 32'h333);
      chk("t4_stall_m0_wq", m0_waitrequest, 1);
      tick();
    end
    s_waitrequest = 0;
    #1;
    chk("t4_accept_m0_grant", m0_waitrequest, 0);
    tick();
    clear_inputs();
    tick();

    // Continuous reads from both: strict alternation from reset.
    do_reset(1);
    m0_read = 1; m1_read = 1;
    for (int i = 0; i < 8; i++) begin
      s_readdatavalid = (i > 0);
      s_readdata = 16'(i * 16'h0101);
      #1;
      chk("t2_m0_wq", m0_waitrequest, (i % 2));
      chk("t2_m1_wq", m1_waitrequest, 1 - (i % 2));
      if (i > 0) chk("t2_no_gap", s_read, 1);
      tick();
    end
    clear_inputs();
    s_readdatavalid = 1;
    tick();
    clear_inputs();
    tick();

    // Pending limit.
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      m0_read = 1; m0_address = 24'(i);
      tick();
    end
    m1_write = 1;
    #1;
    chk("t5_m0_blocked", m0_waitrequest, 1);
    chk("t5_m1_granted", m1_waitrequest, 0);
    tick();
    m1_write = 0; s_readdatavalid = 1; s_readdata = 16'h0F0F;
    #1;
    chk("t5_pop_no_unblock", m0_waitrequest, 1);
    tick();
    s_readdatavalid = 0;
    #1;
    chk("t5_unblocked", m0_waitrequest, 0);
    tick();
    m0_read = 0;
    for (int i = 0; i < 5; i++) begin
      s_readdatavalid = 1;
      tick();
    end
    clear_inputs();
    tick();

    // Reset with reads outstanding; a later return is an orphan.
    do_reset(1);
    m0_read = 1;
    tick();
    m0_read = 0; m1_read = 1;
    tick();
    m1_read = 0; m0_read = 1;
    rst_n = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_rst_m0_wq", m0_waitrequest, 1);
      chk("t6_rst_s_read", s_read, 0);
      tick();
    end
    rst_n = 1;
    m0_read = 0; s_readdatavalid = 1; s_readdata = 16'h7777;
    tick();
    s_readdatavalid = 0;
    #1;
    chk("t6_orphan", err_orphan, 1);
    chk("t6_no_rdv0", m0_readdatavalid, 0);
    chk("t6_no_rdv1", m1_readdatavalid, 0);
    tick();

    // Randomized traffic.
    do_reset(1);
    for (int i = 0; i < 1500; i++) begin
      m0_write = ($urandom % 4 == 0);
      m0_read  = m0_write ? ($urandom % 25 == 0) : ($urandom % 2 == 1);
      m1_write = ($urandom % 4 == 0);
      m1_read  = m1_write ? ($urandom % 25 == 0) : ($urandom % 2 == 1);
      m0_address = 24'($urandom); m1_address = 24'($urandom);
      m0_writedata = 16'($urandom); m1_writedata = 16'($urandom);
      m0_byteenable = 2'($urandom); m1_byteenable = 2'($urandom);
      s_waitrequest = ($urandom % 3 == 0);
      s_readdata = 16'($urandom);
      s_readdatavalid = (mq.size() != 0) ? ($urandom % 2 == 1) : ($urandom % 40 == 0);
      if ($urandom % 250 == 0) begin
        do_reset(1 + ($urandom % 2));
      end else begin
        tick();
      end
    end
    clear_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
